// File: rtl/frontend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frontend_pkg
// Purpose  : Shared serialiser state encoding and frame-length helper.
// Revision : 1.0 - initial release
// ============================================================================
package frontend_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_GAP   = 3'd4
  } tx_state_t;

  // Cycles from start bit to the last idle cycle of one frame.
  function automatic int frame_len(input int length, input int lines,
                                   input int parity, input int gap);
    return 1 + (length / lines) + parity + gap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : data_tx_fifo_if
// Purpose  : Valid/ready word handshake feeding the transmit FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface data_tx_fifo_if #(
  parameter int LENGTH = 32
);
  logic              valid;
  logic              ready;
  logic [LENGTH-1:0] data_in;

  modport master (output valid, output data_in, input ready);
  modport slave  (input valid, input data_in, output ready);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock word FIFO with occupancy count and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_lw-1:0]  r_level;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_level == c_lw'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full && !clear;
  assign w_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      if (w_push && !w_pop)      r_level <= r_level + c_lw'(1);
      else if (w_pop && !w_push) r_level <= r_level - c_lw'(1);
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end
endmodule
`default_nettype wire

// File: rtl/data_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : data_tx_fifo
// Purpose  : Buffers command words and serialises each across LINES outputs.
// Revision : 1.0 - initial release
// ============================================================================
module data_tx_fifo
  import frontend_pkg::*;
#(
  parameter int LENGTH = 32,
  parameter int LINES  = 1,
  parameter int DEPTH  = 4,
  parameter int GAP    = 2,
  parameter int PARITY = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  data_tx_fifo_if.slave              bus,
  output logic [LINES-1:0]           d,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int c_w         = LENGTH / LINES;
  localparam int c_frame_len = frame_len(LENGTH, LINES, PARITY, GAP);
  localparam int c_cnt_w     = $clog2(c_frame_len);
  localparam logic [c_cnt_w-1:0] c_data_last  = c_cnt_w'(c_w);
  localparam logic [c_cnt_w-1:0] c_frame_last = c_cnt_w'(c_frame_len - 1);

  tx_state_t          r_state;
  tx_state_t          w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [LENGTH-1:0]  r_word;
  logic [LINES-1:0]   r_par;
  logic               r_rdy_en;
  logic [LENGTH-1:0]  w_fifo_dout;
  logic [LENGTH-1:0]  w_word_shift;
  logic [LINES-1:0]   w_slice_msb;
  logic [LINES-1:0]   w_fifo_par;
  logic [LINES-1:0]   w_d_next;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign bus.ready = r_rdy_en && !w_full && !clear;
  assign w_push    = bus.valid && bus.ready;
  assign w_pop     = (w_next_state == S_START);
  assign busy      = (r_state != S_IDLE) || !w_empty;

  sync_fifo #(
    .WIDTH (LENGTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.data_in),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  // Each line owns a W-bit slice that shifts left so its MSB is always next out.
  for (genvar k = 0; k < LINES; k++) begin : g_line
    assign w_slice_msb[k] = r_word[k*c_w + c_w - 1];
    assign w_fifo_par[k]  = ^w_fifo_dout[k*c_w +: c_w];
    if (c_w > 1) begin : g_shift
      assign w_word_shift[k*c_w +: c_w] = {r_word[k*c_w +: c_w-1], 1'b0};
    end else begin : g_single
      assign w_word_shift[k*c_w] = 1'b0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next_state = S_START;
      S_START: w_next_state = S_DATA;
      S_DATA:  if (r_cnt == c_data_last) w_next_state = (PARITY != 0) ? S_PAR : S_GAP;
      S_PAR:   w_next_state = S_GAP;
      S_GAP:   if (r_cnt == c_frame_last) w_next_state = w_empty ? S_IDLE : S_START;
      default: w_next_state = S_IDLE;
    endcase
    if (clear) w_next_state = S_IDLE;

    // d is registered, so it is driven from the state being entered.
    w_d_next = '0;
    case (w_next_state)
      S_START: w_d_next = '1;
      S_DATA:  w_d_next = w_slice_msb;
      S_PAR:   w_d_next = r_par;
      default: w_d_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_word   <= '0;
      r_par    <= '0;
      r_rdy_en <= 1'b0;
      d        <= '0;
    end else begin
      r_state  <= w_next_state;
      r_rdy_en <= 1'b1;
      d        <= w_d_next;
      if (w_pop) begin
        r_word <= w_fifo_dout;
        r_par  <= w_fifo_par;
      end else if (w_next_state == S_DATA) begin
        r_word <= w_word_shift;
      end
      if (w_next_state == S_START || w_next_state == S_IDLE) r_cnt <= '0;
      else                                                   r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end
endmodule
`default_nettype wire

// File: doc/data_tx_fifo.md
DATA_TX_FIFO -- requirements
Module: data_tx_fifo

Interface
REQ-001 The block SHALL have parameter LENGTH, default 32, meaning command word width in bits.
REQ-002 The block SHALL have parameter LINES, default 1, meaning the number of serial output lines; LENGTH % LINES == 0; W = LENGTH/LINES bits per line.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning word FIFO depth (>=2, power of two).
REQ-004 The block SHALL have parameter GAP, default 2, meaning idle-low cycles after each frame (>=1).
REQ-005 The block SHALL have parameter PARITY, default 0, meaning 1 appends one even-parity bit per line.
REQ-006 The block SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port clear  input  1  synchronous flush of the FIFO and abort of the current frame.
REQ-009 The block SHALL have port valid  input  1  data_in is offered.
REQ-010 The block SHALL have port ready  output  1  the FIFO can accept a word.
REQ-011 The block SHALL have port data_in  input  LENGTH  command word.
REQ-012 The block SHALL have port d  output  LINES  serial data lines, registered.
REQ-013 The block SHALL have port busy  output  1  a frame is in progress or the FIFO is non-empty.
REQ-014 The block SHALL have port level  output  $clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-015 A word SHALL be accepted on every edge where valid && ready; ready SHALL equal (level != DEPTH) && !clear.
REQ-016 Words SHALL be transmitted in acceptance order; no word SHALL be dropped or duplicated.
REQ-017 Frame on line k (0..LINES-1): 1 start cycle d[k]=1; then W data cycles of data_in[(k+1)*W-1 : k*W], MSB first; then, if PARITY, 1 cycle of even parity (XOR) of that slice; then GAP cycles d[k]=0.
REQ-018 All lines SHALL start and end each frame in the same cycle; frame length F = 1 + W + PARITY + GAP.
REQ-019 The state machine SHALL use states IDLE, START, DATA, PAR, GAP; IDLE->START when FIFO non-empty; START->DATA; DATA->PAR (PARITY=1) or GAP after W cycles; PAR->GAP; GAP->START if FIFO non-empty at last GAP cycle, else IDLE.
REQ-020 From IDLE with empty FIFO, a word accepted at edge t SHALL pop at edge t+1 and d SHALL show the start bit from edge t+1 (latency 1 cycle).
REQ-021 Back-to-back words SHALL be separated by exactly GAP idle cycles, with no extra idle.
REQ-022 Push and pop on the same edge SHALL leave level unchanged; pop SHALL occur on the edge entering START.
REQ-023 When full, ready SHALL be 0 and the pop that frees a slot SHALL raise ready on the following cycle.
REQ-024 clear SHALL, at the next edge, empty the FIFO (level=0), force IDLE and d=0, and take priority over a simultaneous push or pop.
REQ-025 In IDLE, d SHALL be all zeros.

Reset
REQ-026 When rst=0, the block SHALL immediately (asynchronously) set d=0, level=0, busy=0 and ready=0, put the FSM in IDLE, and reset the FIFO pointers; FIFO storage SHALL not be reset.
REQ-027 ready SHALL assert on the first edge after rst deasserts; reset mid-frame SHALL truncate the frame with no further bits.

Structure
REQ-028 FSM state encoding SHALL live in a shared package, frontend_pkg, together with a frame-length function F(LENGTH, LINES, PARITY, GAP).
REQ-029 The FIFO SHALL be the sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, level, clear); the serialiser SHALL stay in data_tx_fifo.

Verification
REQ-030 Defaults, single push of 32'hF000_0000: d = 1, 1111, then 28 zeros, then 2 idle cycles; busy high for 35 cycles, then 0.
REQ-031 LINES=4, PARITY=1, push 32'h70C0_0001: the start cycle shows d=4'hF; line3 carries 0x70 then parity 1, line2 0xC0 then 0, line1 0x00 then 0, line0 0x01 then 1; frame is 12 cycles.
REQ-032 Push 6 words back-to-back with DEPTH=4: ready drops when level=4; all 6 words are emitted in order with exactly 2 idle cycles between frames.
REQ-033 Assert clear during the DATA state with level=3: the next edge gives d=0, level=0 and IDLE; a subsequent push starts a clean frame.
REQ-034 Drop rst mid-frame: d=0 immediately; after release, ready=1 one edge later and nothing resumes.
REQ-035 Random valid with held data_in (scoreboard over 1000 words): the output word sequence equals the accepted word sequence.
